// File: rtl/i3c_data_tobus_fifo.sv
// rtl/i3c_data_tobus_fifo.sv - to-bus byte FIFO from system writes to the I3C engine
module i3c_data_tobus_fifo #(
    parameter int BITS = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       tb_wr_valid,
    input  logic [7:0] tb_wr_data,
    input  logic       tb_wr_end,
    output logic       tb_wr_full,
    input  logic       tb_flush,
    input  logic [1:0] tx_trig,
    output logic       int_tx,
    output logic [4:0] avail_byte_cnt,
    output logic [7:0] tb_datab,
    output logic       tb_end,
    output logic       tb_datab_ready,
    input  logic       tb_datab_ack,
    input  logic       tb_datab_req,
    output logic       set_tb_orun,
    input  logic       clear_tb_orun,
    output logic       set_tb_urun,
    input  logic       clear_tb_urun
);

    localparam int DEPTH = 1 << BITS;
    localparam logic [BITS:0] IDX_ONE = 1;
    localparam logic [4:0] TH_QUARTER = 5'(DEPTH / 4);
    localparam logic [4:0] TH_HALF    = 5'(DEPTH / 2);
    localparam logic [4:0] TH_3QUART  = 5'((3 * DEPTH) / 4);

    logic [8:0]    mem [DEPTH];
    logic [BITS:0] widx;
    logic [BITS:0] ridx;
    logic [BITS:0] diff;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;

    // Wrap bit distinguishes full from empty when the low index bits match.
    assign empty = (widx == ridx);
    assign full  = (widx[BITS] != ridx[BITS]) && (widx[BITS-1:0] == ridx[BITS-1:0]);
    assign diff  = widx - ridx;
    assign push  = tb_wr_valid & ~full & ~tb_flush;
    assign pop   = tb_datab_ack & ~empty & ~tb_flush;

    assign avail_byte_cnt = 5'(diff);
    assign tb_wr_full     = full;
    assign tb_datab_ready = ~empty;
    assign {tb_end, tb_datab} = mem[ridx[BITS-1:0]];

    always_comb begin
        int_tx = 1'b0;
        case (tx_trig)
            2'b00:   int_tx = (avail_byte_cnt == 5'd0);
            2'b01:   int_tx = (avail_byte_cnt <= TH_QUARTER);
            2'b10:   int_tx = (avail_byte_cnt <= TH_HALF);
            default: int_tx = (avail_byte_cnt <= TH_3QUART);
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            widx        <= '0;
            ridx        <= '0;
            set_tb_orun <= 1'b0;
            set_tb_urun <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (tb_flush) begin
                widx <= '0;
                ridx <= '0;
            end else begin
                if (push) begin
                    mem[widx[BITS-1:0]] <= {tb_wr_end, tb_wr_data};
                    widx <= widx + IDX_ONE;
                end
                if (pop) begin
                    ridx <= ridx + IDX_ONE;
                end
            end
            // Set beats clear when both happen in the same cycle.
            set_tb_orun <= (set_tb_orun & ~clear_tb_orun) | (tb_wr_valid & full & ~tb_flush);
            set_tb_urun <= (set_tb_urun & ~clear_tb_urun) | (tb_datab_req & empty);
        end
    end

endmodule

// File: tb/tb_i3c_data_tobus_fifo.sv
// tb/tb_i3c_data_tobus_fifo.sv - queue-model bench for the to-bus byte FIFO
module tb_i3c_data_tobus_fifo;

    localparam int BITS  = 3;
    localparam int DEPTH = 1 << BITS;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       tb_wr_valid = 1'b0;
    logic [7:0] tb_wr_data = '0;
    logic       tb_wr_end = 1'b0;
    logic       tb_wr_full;
    logic       tb_flush = 1'b0;
    logic [1:0] tx_trig = 2'b00;
    logic       int_tx;
    logic [4:0] avail_byte_cnt;
    logic [7:0] tb_datab;
    logic       tb_end;
    logic       tb_datab_ready;
    logic       tb_datab_ack = 1'b0;
    logic       tb_datab_req = 1'b0;
    logic       set_tb_orun;
    logic       clear_tb_orun = 1'b0;
    logic       set_tb_urun;
    logic       clear_tb_urun = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [8:0] q[$];
    bit         m_orun = 0;
    bit         m_urun = 0;

    i3c_data_tobus_fifo #(.BITS(BITS)) dut (
        .CLK(CLK), .RST(RST),
        .tb_wr_valid(tb_wr_valid), .tb_wr_data(tb_wr_data), .tb_wr_end(tb_wr_end),
        .tb_wr_full(tb_wr_full), .tb_flush(tb_flush), .tx_trig(tx_trig),
        .int_tx(int_tx), .avail_byte_cnt(avail_byte_cnt),
        .tb_datab(tb_datab), .tb_end(tb_end), .tb_datab_ready(tb_datab_ready),
        .tb_datab_ack(tb_datab_ack), .tb_datab_req(tb_datab_req),
        .set_tb_orun(set_tb_orun), .clear_tb_orun(clear_tb_orun),
        .set_tb_urun(set_tb_urun), .clear_tb_urun(clear_tb_urun)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_int_tx(input int n, input logic [1:0] trig);
        case (trig)
            2'b00:   return n == 0;
            2'b01:   return n <= DEPTH / 4;
            2'b10:   return n <= DEPTH / 2;
            default: return n <= (3 * DEPTH) / 4;
        endcase
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".ready"}, 32'(tb_datab_ready), 32'(q.size() != 0));
        chk({tag, ".full"},  32'(tb_wr_full), 32'(q.size() == DEPTH));
        chk({tag, ".cnt"},   32'(avail_byte_cnt), 32'(q.size()));
        chk({tag, ".int"},   32'(int_tx), 32'(exp_int_tx(q.size(), tx_trig)));
        chk({tag, ".orun"},  32'(set_tb_orun), 32'(m_orun));
        chk({tag, ".urun"},  32'(set_tb_urun), 32'(m_urun));
        if (q.size() != 0) begin
            chk({tag, ".head"}, 32'({tb_end, tb_datab}), 32'(q[0]));
        end
    endtask

    // Reference behaviour evaluated from pre-edge state and current inputs.
    task automatic model_step();
        bit was_full  = (q.size() == DEPTH);
        bit was_empty = (q.size() == 0);
        m_orun = (m_orun && !clear_tb_orun) || (tb_wr_valid && was_full && !tb_flush);
        m_urun = (m_urun && !clear_tb_urun) || (tb_datab_req && was_empty);
        if (tb_flush) begin
            q.delete();
        end else begin
            if (tb_datab_ack && !was_empty) void'(q.pop_front());
            if (tb_wr_valid && !was_full) q.push_back({tb_wr_end, tb_wr_data});
        end
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge CLK);
        #1;
        tb_wr_valid = 0; tb_wr_end = 0; tb_datab_ack = 0; tb_datab_req = 0;
        tb_flush = 0; clear_tb_orun = 0; clear_tb_urun = 0;
        check_all(tag);
    endtask

    task automatic push_b(input logic [7:0] d, input logic e, input string tag);
        tb_wr_valid = 1; tb_wr_data = d; tb_wr_end = e;
        tick(tag);
    endtask

    task automatic ack_b(input string tag);
        tb_datab_ack = 1;
        tick(tag);
    endtask

    initial begin
        // Reset state under every trigger setting
        #12;
        for (int t = 0; t < 4; t++) begin
            tx_trig = 2'(t);
            #1;
            chk("rst.int", 32'(int_tx), 32'd1);
        end
        tx_trig = 2'b00;
        chk("rst.ready", 32'(tb_datab_ready), 32'd0);
        chk("rst.head", 32'({tb_end, tb_datab}), 32'd0);
        check_all("rst");
        @(negedge CLK);
        RST = 0;
        @(posedge CLK); #1;

        // Basic three-byte message
        push_b(8'h11, 0, "p1");
        push_b(8'h22, 0, "p2");
        push_b(8'h33, 1, "p3");
        chk("msg.cnt", 32'(avail_byte_cnt), 32'd3);
        chk("msg.head", 32'(tb_datab), 32'h11);
        ack_b("a1");
        chk("msg.h2", 32'(tb_datab), 32'h22);
        ack_b("a2");
        chk("msg.h3", 32'({tb_end, tb_datab}), 32'h133);
        ack_b("a3");
        chk("msg.empty", 32'(tb_datab_ready), 32'd0);

        // Fill past full, overrun, ack, clear
        for (int i = 0; i < 9; i++) push_b(8'(i), 0, "fill");
        chk("fill.full", 32'(tb_wr_full), 32'd1);
        chk("fill.orun", 32'(set_tb_orun), 32'd1);
        tb_wr_valid = 1; tb_wr_data = 8'hEE; tb_datab_ack = 1;
        tick("full_push_ack");
        chk("fpa.head", 32'(tb_datab), 32'h01);
        chk("fpa.full", 32'(tb_wr_full), 32'd0);
        clear_tb_orun = 1;
        tick("clr_orun");
        chk("clr.orun", 32'(set_tb_orun), 32'd0);
        while (q.size() != 0) ack_b("drain");

        // Streaming at occupancy 4 across multiple wraps
        for (int i = 0; i < 4; i++) push_b(8'($urandom), 1'($urandom), "pre4");
        for (int i = 0; i < 40; i++) begin
            tb_wr_valid = 1; tb_wr_data = 8'($urandom); tb_wr_end = 1'($urandom);
            tb_datab_ack = 1;
            tick("stream");
        end
        chk("stream.cnt", 32'(avail_byte_cnt), 32'd4);
        while (q.size() != 0) ack_b("drain2");

        // Underrun with simultaneous push; set wins over clear
        tb_datab_req = 1; tb_wr_valid = 1; tb_wr_data = 8'h5A;
        tick("urun_push");
        chk("urun.set", 32'(set_tb_urun), 32'd1);
        chk("urun.head", 32'(tb_datab), 32'h5A);
        ack_b("urun_ack");
        tb_datab_req = 1; clear_tb_urun = 1;
        tick("urun_setwin");
        chk("urun.win", 32'(set_tb_urun), 32'd1);
        clear_tb_urun = 1;
        tick("urun_clr");

        // Thresholds at count 5
        for (int i = 0; i < 5; i++) push_b(8'(8'h40 + i), 0, "pre5");
        tx_trig = 2'b01; #1; chk("trig01", 32'(int_tx), 32'd0);
        tx_trig = 2'b10; #1; chk("trig10", 32'(int_tx), 32'd0);
        tx_trig = 2'b11; #1; chk("trig11", 32'(int_tx), 32'd1);
        tb_flush = 1; tb_wr_valid = 1; tb_wr_data = 8'h99;
        tick("flush_push");
        chk("flush.cnt", 32'(avail_byte_cnt), 32'd0);
        chk("flush.orun", 32'(set_tb_orun), 32'd0);

        // Asynchronous reset mid-burst
        for (int i = 0; i < 6; i++) push_b(8'(8'hA0 + i), 1'(i == 5), "pre6");
        #3;
        RST = 1;
        #1;
        q.delete(); m_orun = 0; m_urun = 0;
        check_all("arst");
        chk("arst.head", 32'({tb_end, tb_datab}), 32'd0);
        @(posedge CLK); #1;
        RST = 0;

        // Randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            tx_trig       = 2'($urandom);
            tb_wr_valid   = ($urandom_range(0, 99) < 55);
            tb_wr_data    = 8'($urandom);
            tb_wr_end     = 1'($urandom);
            tb_datab_ack  = ($urandom_range(0, 99) < 45);
            tb_datab_req  = ($urandom_range(0, 99) < 20);
            tb_flush      = ($urandom_range(0, 63) == 0);
            clear_tb_orun = ($urandom_range(0, 15) == 0);
            clear_tb_urun = ($urandom_range(0, 15) == 0);
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
